restoring_divider_param: RTL and testbench

- Parametrised sequential unsigned integer divider using the restoring algorithm, one quotient bit per clock.
- Successor to the fixed 24-bit divider; adds:
  - a WIDTH parameter
  - a remainder output
  - a busy output
  - divide-by-zero detection
  - a fixed, data-independent latency
  - optional signed mode
- Sits beside the datapath as a multi-cycle arithmetic unit, driven by a start/done handshake.

---
 rtl/divider_pkg.sv | 29 ++
 rtl/div_restore_step.sv | 39 +++
 rtl/restoring_divider_param.sv | 178 +++++++++++++++++
 tb/tb_restoring_divider_param.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
//   Shared definitions for the restoring divider:
//     - state_e        : FSM state encoding (IDLE / CALC)
//     - cnt_width()    : width of the iteration counter for a given WIDTH
//     - DIV_ZERO_QUOT  : quotient returned on divide-by-zero (all ones)
//     - RESET_RESULT   : reset value of the result registers
//     - RESET_STATE    : reset state of the FSM
//   Constants are sized to the largest legal WIDTH (64); users slice them.
// -----------------------------------------------------------------------------
package divider_pkg;

  localparam int MAX_WIDTH = 64;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_e;

  localparam state_e                 RESET_STATE   = IDLE;
  localparam logic [MAX_WIDTH-1:0]   DIV_ZERO_QUOT = '1;
  localparam logic [MAX_WIDTH-1:0]   RESET_RESULT  = '0;

  // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// -----------------------------------------------------------------------------
// div_restore_step
//   One combinational iteration of the restoring division algorithm.
//   Ports:
//     r_i       in  WIDTH  partial remainder
//     q_i       in  WIDTH  dividend / quotient shift register
//     divisor_i in  WIDTH  divisor (unsigned magnitude)
//     r_o       out WIDTH  next partial remainder
//     q_o       out WIDTH  next shift register (new quotient bit in LSB)
//   The restored remainder is always below the divisor, so it fits in WIDTH
//   bits; only the trial subtraction needs the extra bit.
// -----------------------------------------------------------------------------
module div_restore_step #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] r_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {r_i, q_i[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor_i};

  // NOTE: every output gets a value on every path so no latch is inferred.
  always_comb begin
    r_o = shifted[WIDTH-1:0];
    q_o = {q_i[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      r_o = trial[WIDTH-1:0];
      q_o = {q_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/restoring_divider_param.sv
// -----------------------------------------------------------------------------
// restoring_divider_param
//   Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   Latency is WIDTH cycles from the accepting edge to done (1 cycle for a
//   zero divisor), independent of the operand values.
//   Ports:
//     clk          in  1      clock, rising edge
//     reset_n      in  1      asynchronous active-low reset
//     signed_mode  in  1      two's complement operands (RESTORING_DIVIDER_SIGNED_EN only)
//     start        in  1      request a division, sampled while busy=0
//     dividend     in  WIDTH  numerator, captured on the accepting edge
//     divisor      in  WIDTH  denominator, captured on the accepting edge
//     quotient     out WIDTH  registered result, held until next completion
//     remainder    out WIDTH  registered result, held until next completion
//     busy         out 1      high while iterating
//     done         out 1      one-cycle pulse when results update
//     div_by_zero  out 1      captured divisor was zero
//   Optional feature macro: RESTORING_DIVIDER_SIGNED_EN (signed truncating
//   division; the core still iterates on magnitudes).
// -----------------------------------------------------------------------------
module restoring_divider_param
  import divider_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset_n,
`ifdef RESTORING_DIVIDER_SIGNED_EN
  input  logic             signed_mode,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int               CW  = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dbz_pend_q, dbz_pend_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic             sgn_mode;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH-1:0] sh_nxt;

`ifdef RESTORING_DIVIDER_SIGNED_EN
  assign sgn_mode = signed_mode;
`else
  assign sgn_mode = 1'b0;
`endif

  // Magnitudes at capture; the most-negative value maps to 2^(WIDTH-1),
  // which is still correct as an unsigned magnitude.
  assign dividend_mag = (sgn_mode && dividend[WIDTH-1]) ? (~dividend + ONE) : dividend;
  assign divisor_mag  = (sgn_mode && divisor[WIDTH-1])  ? (~divisor + ONE)  : divisor;

  div_restore_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r_i       (r_q),
    .q_i       (sh_q),
    .divisor_i (dvs_q),
    .r_o       (r_nxt),
    .q_o       (sh_nxt)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    r_d         = r_q;
    sh_d        = sh_q;
    dvs_d       = dvs_q;
    neg_quot_d  = neg_quot_q;
    neg_rem_d   = neg_rem_q;
    dbz_pend_d  = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    done_d      = 1'b0;
    dbz_d       = dbz_q;

    // Divide-by-zero completes one edge after acceptance; sh_q still holds
    // the raw dividend because nothing else can load it while IDLE.
    if (dbz_pend_q) begin
      quotient_d  = DIV_ZERO_QUOT[WIDTH-1:0];
      remainder_d = sh_q;
      dbz_d       = 1'b1;
      done_d      = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          dvs_d      = divisor_mag;
          neg_quot_d = sgn_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_rem_d  = sgn_mode & dividend[WIDTH-1];
          if (divisor == '0) begin
            sh_d       = dividend;
            dbz_pend_d = 1'b1;
          end else begin
            r_d     = '0;
            sh_d    = dividend_mag;
            cnt_d   = CW'(WIDTH);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        r_d   = r_nxt;
        sh_d  = sh_nxt;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quotient_d  = neg_quot_q ? (~sh_nxt + ONE) : sh_nxt;
          remainder_d = neg_rem_q  ? (~r_nxt + ONE)  : r_nxt;
          dbz_d       = 1'b0;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RESET_STATE;
      cnt_q       <= '0;
      r_q         <= '0;
      sh_q        <= '0;
      dvs_q       <= '0;
      neg_quot_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
      dbz_pend_q  <= 1'b0;
      quotient_q  <= RESET_RESULT[WIDTH-1:0];
      remainder_q <= RESET_RESULT[WIDTH-1:0];
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      r_q         <= r_d;
      sh_q        <= sh_d;
      dvs_q       <= dvs_d;
      neg_quot_q  <= neg_quot_d;
      neg_rem_q   <= neg_rem_d;
      dbz_pend_q  <= dbz_pend_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign busy        = (state_q == CALC);
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider_param.sv
// -----------------------------------------------------------------------------
// tb_restoring_divider_param
//   Directed and randomized checks of restoring_divider_param at WIDTH 8, 24
//   and 32. Expected results come from plain integer division in model().
// -----------------------------------------------------------------------------
module tb_restoring_divider_param;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH = 24
  logic        st24 = 1'b0, sm24 = 1'b0;
  logic [23:0] d24 = '0, v24 = '0, q24, r24;
  logic        busy24, done24, dbz24;
  // WIDTH = 8
  logic        st8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  d8 = '0, v8 = '0, q8, r8;
  logic        busy8, done8, dbz8;
  // WIDTH = 32
  logic        st32 = 1'b0, sm32 = 1'b0;
  logic [31:0] d32 = '0, v32 = '0, q32, r32;
  logic        busy32, done32, dbz32;

  int n_cmp = 0;
  int n_err = 0;

  restoring_divider_param #(.WIDTH(24)) u24 (
    .clk(clk), .reset_n(reset_n),
`ifdef RESTORING_DIVIDER_SIGNED_EN
    .signed_mode(sm24),
`endif
    .start(st24), .dividend(d24), .divisor(v24),
    .quotient(q24), .remainder(r24), .busy(busy24), .done(done24), .div_by_zero(dbz24)
  );

  restoring_divider_param #(.WIDTH(8)) u8 (
    .clk(clk), .reset_n(reset_n),
`ifdef RESTORING_DIVIDER_SIGNED_EN
    .signed_mode(sm8),
`endif
    .start(st8), .dividend(d8), .divisor(v8),
    .quotient(q8), .remainder(r8), .busy(busy8), .done(done8), .div_by_zero(dbz8)
  );

  restoring_divider_param #(.WIDTH(32)) u32 (
    .clk(clk), .reset_n(reset_n),
`ifdef RESTORING_DIVIDER_SIGNED_EN
    .signed_mode(sm32),
`endif
    .start(st32), .dividend(d32), .divisor(v32),
    .quotient(q32), .remainder(r32), .busy(busy32), .done(done32), .div_by_zero(dbz32)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Unsigned reference: divide-by-zero returns all ones and the dividend.
  task automatic model(input logic [63:0] a, input logic [63:0] b, input int w,
                       output logic [63:0] q, output logic [63:0] r);
    logic [63:0] mask;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    if (b == 0) begin
      q = mask;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done on the 24-bit unit; lat counts edges since the caller's
  // accepting edge (-1 on timeout), bsy counts sampled busy cycles.
  task automatic wait_done24(output int lat, output int bsy);
    lat = -1;
    bsy = 0;
    for (int n = 1; n <= 64; n++) begin
      if (busy24) bsy++;
      tick();
      if (done24) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run24(input logic [23:0] a, input logic [23:0] b, input logic sm,
                       output int lat, output int bsy);
    d24  = a;
    v24  = b;
    sm24 = sm;
    st24 = 1'b1;
    tick();
    st24 = 1'b0;
    d24  = 24'($urandom);
    v24  = 24'($urandom);
    wait_done24(lat, bsy);
  endtask

  function automatic logic [63:0] pick_divisor(input int w);
    logic [63:0] v;
    case ($urandom_range(0, 9))
      0:       v = 64'd0;
      1, 2, 3: v = 64'($urandom_range(1, 15));
      default: v = {32'($urandom), 32'($urandom)};
    endcase
    return (w == 64) ? v : (v & ((64'd1 << w) - 64'd1));
  endfunction

  initial begin
    int lat, bsy, ndone;
    logic [63:0] eq, er;

    // ---------------- reset state ----------------
    #12;
    check("rst_quotient", q24, 0);
    check("rst_remainder", r24, 0);
    check("rst_busy", busy24, 0);
    check("rst_done", done24, 0);
    check("rst_dbz", dbz24, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // ---------------- 1000 / 7 ----------------
    run24(24'd1000, 24'd7, 1'b0, lat, bsy);
    check("t1_latency", lat, 24);
    check("t1_busy_cycles", bsy, 24);
    check("t1_quotient", q24, 142);
    check("t1_remainder", r24, 6);
    check("t1_dbz", dbz24, 0);
    tick();
    check("t1_done_pulse", done24, 0);
    check("t1_hold_quot", q24, 142);

    // ---------------- boundaries ----------------
    run24(24'hFFFFFF, 24'd1, 1'b0, lat, bsy);
    check("t2_quotient", q24, 24'hFFFFFF);
    check("t2_remainder", r24, 0);
    run24(24'd5, 24'd9, 1'b0, lat, bsy);
    check("t2b_quotient", q24, 0);
    check("t2b_remainder", r24, 5);

    // ---------------- divide by zero ----------------
    run24(24'h123456, 24'd0, 1'b0, lat, bsy);
    check("t3_latency", lat, 1);
    check("t3_busy_cycles", bsy, 0);
    check("t3_quotient", q24, 24'hFFFFFF);
    check("t3_remainder", r24, 24'h123456);
    check("t3_dbz", dbz24, 1);
    check("t3_busy_after", busy24, 0);

    // ---------------- start while busy is ignored ----------------
    d24 = 24'd100; v24 = 24'd3; sm24 = 1'b0; st24 = 1'b1;
    tick();
    st24 = 1'b0;
    repeat (4) tick();
    d24 = 24'd50; v24 = 24'd5; st24 = 1'b1;
    tick();
    st24 = 1'b0; d24 = 24'd7; v24 = 24'd2;
    wait_done24(lat, bsy);
    check("t4_latency", lat, 19);
    check("t4_quotient", q24, 33);
    check("t4_remainder", r24, 1);
    check("t4_dbz", dbz24, 0);
    // start issued in the done cycle: accepted without a bubble
    run24(24'd50, 24'd5, 1'b0, lat, bsy);
    check("t4b_latency", lat, 24);
    check("t4b_quotient", q24, 10);
    check("t4b_remainder", r24, 0);

    // ---------------- reset mid-operation ----------------
    d24 = 24'd1234; v24 = 24'd5; st24 = 1'b1;
    tick();
    st24 = 1'b0;
    repeat (9) tick();
    #2 reset_n = 1'b0;
    #1;
    check("t5_rst_busy", busy24, 0);
    check("t5_rst_quot", q24, 0);
    check("t5_rst_rem", r24, 0);
    check("t5_rst_done", done24, 0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    ndone = 0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (done24) ndone++;
    end
    check("t5_no_done", ndone, 0);
    run24(24'd81, 24'd9, 1'b0, lat, bsy);
    check("t5_quotient", q24, 9);
    check("t5_remainder", r24, 0);

`ifdef RESTORING_DIVIDER_SIGNED_EN
    // ---------------- signed mode ----------------
    run24(24'hFFFF9C, 24'd7, 1'b1, lat, bsy);
    check("s1_latency", lat, 24);
    check("s1_quotient", q24, 24'hFFFFF2);
    check("s1_remainder", r24, 24'hFFFFFE);
    run24(24'h800000, 24'hFFFFFF, 1'b1, lat, bsy);
    check("s2_quotient", q24, 24'h800000);
    check("s2_remainder", r24, 0);
    run24(24'hFFFF9C, 24'd0, 1'b1, lat, bsy);
    check("s3_latency", lat, 1);
    check("s3_quotient", q24, 24'hFFFFFF);
    check("s3_remainder", r24, 24'hFFFF9C);
    check("s3_dbz", dbz24, 1);
    sm24 = 1'b0;
`endif

    // ---------------- random regression, three widths in parallel ----------------
    for (int it = 0; it < 40; it++) begin
      logic [63:0] a8, b8, a24, b24, a32, b32;
      logic [63:0] eq8, er8, eq24, er24, eq32, er32;
      bit seen8, seen24, seen32;
      a8  = 64'($urandom_range(0, 255));
      b8  = pick_divisor(8);
      a24 = 64'($urandom) & 64'hFFFFFF;
      b24 = pick_divisor(24);
      a32 = 64'($urandom);
      b32 = pick_divisor(32);
      model(a8, b8, 8, eq8, er8);
      model(a24, b24, 24, eq24, er24);
      model(a32, b32, 32, eq32, er32);
      d8 = a8[7:0];   v8 = b8[7:0];
      d24 = a24[23:0]; v24 = b24[23:0];
      d32 = a32[31:0]; v32 = b32[31:0];
      st8 = 1'b1; st24 = 1'b1; st32 = 1'b1;
      tick();
      st8 = 1'b0; st24 = 1'b0; st32 = 1'b0;
      d8 = 8'($urandom); d24 = 24'($urandom); d32 = $urandom;
      v8 = 8'($urandom); v24 = 24'($urandom); v32 = $urandom;
      seen8 = 0; seen24 = 0; seen32 = 0;
      for (int n = 1; n <= 40; n++) begin
        tick();
        if (done8 && !seen8) begin
          seen8 = 1;
          check("rnd8_latency", n, (b8 == 0) ? 1 : 8);
          check("rnd8_quotient", q8, eq8);
          check("rnd8_remainder", r8, er8);
          check("rnd8_dbz", dbz8, b8 == 0);
        end
        if (done24 && !seen24) begin
          seen24 = 1;
          check("rnd24_latency", n, (b24 == 0) ? 1 : 24);
          check("rnd24_quotient", q24, eq24);
          check("rnd24_remainder", r24, er24);
          check("rnd24_dbz", dbz24, b24 == 0);
        end
        if (done32 && !seen32) begin
          seen32 = 1;
          check("rnd32_latency", n, (b32 == 0) ? 1 : 32);
          check("rnd32_quotient", q32, eq32);
          check("rnd32_remainder", r32, er32);
          check("rnd32_dbz", dbz32, b32 == 0);
        end
      end
      check("rnd8_completed", seen8, 1);
      check("rnd24_completed", seen24, 1);
      check("rnd32_completed", seen32, 1);
    end

    // keep eq/er referenced for a final sanity sample against the model
    model(64'd1000, 64'd7, 24, eq, er);
    run24(24'd1000, 24'd7, 1'b0, lat, bsy);
    check("final_quotient", q24, eq);
    check("final_remainder", r24, er);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
